// File: rtl/instr_fetch.sv
// Instruction fetch: drives the imem read port, buffers words, hands off to decode.
// Define IFETCH_WRAP_EN to wrap the PC past the top address instead of stopping.
module instr_fetch #(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_noe,
    output logic              mem_cs,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_END
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [DATA_W-1:0] buf_data [BUF_DEPTH];
    logic [ADDR_W-1:0] buf_pc   [BUF_DEPTH];

    logic has_entry;
    logic pop;
    logic fetch_en;
    logic last_fetch;

    assign has_entry   = (count != '0);
    assign instr_valid = has_entry & ~br_taken;
    assign pop         = instr_valid & instr_ready;
    assign fetch_en    = (state == S_FETCH) & ~br_taken &
                         ((count < CNT_W'(BUF_DEPTH)) | pop);

`ifdef IFETCH_WRAP_EN
    assign last_fetch = 1'b0;
`else
    assign last_fetch = &fetch_pc;
`endif

    assign mem_addr = fetch_pc;
    assign mem_read = fetch_en;
    assign mem_cs   = fetch_en;
    assign mem_noe  = ~fetch_en;
    assign instr    = has_entry ? buf_data[rd_ptr] : '0;
    assign instr_pc = has_entry ? buf_pc[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            fetch_pc <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (br_taken) begin
            fetch_pc <= br_target;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            unique case (state)
                S_IDLE:  state <= S_IDLE;
                S_FETCH: state <= run ? S_FETCH : S_IDLE;
                default: state <= S_FETCH;
            endcase
        end else begin
            if (fetch_en) begin
                buf_data[wr_ptr] <= mem_data;
                buf_pc[wr_ptr]   <= fetch_pc;
                wr_ptr           <= wr_ptr + PTR_W'(1);
                fetch_pc         <= fetch_pc + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(fetch_en) - CNT_W'(pop);
            // Reaching the top address wins over a simultaneous run drop.
            unique case (1'b1)
                state == S_IDLE: begin
                    if (run) state <= S_FETCH;
                end
                state == S_FETCH: begin
                    if (fetch_en && last_fetch) state <= S_END;
                    else if (!run) state <= S_IDLE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_instr_fetch;

    localparam int AW    = 7;
    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int MAXA  = (1 << AW) - 1;

`ifdef IFETCH_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic          instr_ready;
    logic          br_taken;
    logic [AW-1:0] br_target;
    logic [AW-1:0] mem_addr;
    logic          mem_read;
    logic          mem_noe;
    logic          mem_cs;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;

    logic [DW-1:0] mem [1 << AW];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Poison value while the output enable is off exposes illegal sampling.
    assign mem_data = mem_noe ? 32'hBAD0_BAD0 : mem[mem_addr];

    instr_fetch #(.ADDR_W(AW), .DATA_W(DW), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .run(run),
        .mem_addr(mem_addr),
        .mem_read(mem_read),
        .mem_noe(mem_noe),
        .mem_cs(mem_cs),
        .mem_data(mem_data),
        .instr(instr),
        .instr_pc(instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .br_taken(br_taken),
        .br_target(br_target)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        run = 1'b0;
        instr_ready = 1'b0;
        br_taken = 1'b0;
        br_target = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic load_plan_mem;
        for (int i = 0; i <= MAXA; i++) mem[i] = '0;
        mem[0] = 32'hB880_0000;
        mem[1] = 32'hB880_1001;
        mem[2] = 32'h0000_0008;
        mem[9] = 32'h0000_0001;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        run = 1'b0;
        instr_ready = 1'b0;
        br_taken = 1'b0;
        br_target = '0;
        step();
        step();
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({mem_addr, mem_noe, mem_cs, mem_read} !== {7'd0, 3'b100}) begin
            n_err++;
            $display("FAIL reset_mem got addr=%0d noe/cs/rd=%b%b%b exp 0 100",
                     mem_addr, mem_noe, mem_cs, mem_read);
        end
        n_cmp++;
        if ({instr_valid, instr, instr_pc} !== {1'b0, 32'd0, 7'd0}) begin
            n_err++;
            $display("FAIL reset_out got v=%b instr=%h pc=%0d exp 0 0 0",
                     instr_valid, instr, instr_pc);
        end
    endtask

    task automatic test_stream;
        logic [DW-1:0] plan [3];
        plan[0] = 32'hB880_0000;
        plan[1] = 32'hB880_1001;
        plan[2] = 32'h0000_0008;
        do_reset();
        run = 1'b1;
        instr_ready = 1'b1;
        #1;
        n_cmp++;
        if (mem_noe !== 1'b1) begin
            n_err++;
            $display("FAIL stream_idle_noe got %b exp 1", mem_noe);
        end
        step();
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if ({mem_addr, mem_noe, mem_cs, mem_read} !== {7'(k), 3'b011}) begin
                n_err++;
                $display("FAIL stream_fetch k=%0d got addr=%0d noe/cs/rd=%b%b%b exp %0d 011",
                         k, mem_addr, mem_noe, mem_cs, mem_read, k);
            end
            if (k > 0) begin
                n_cmp++;
                if ({instr_valid, instr, instr_pc} !== {1'b1, plan[k-1], 7'(k-1)}) begin
                    n_err++;
                    $display("FAIL stream_instr k=%0d got v=%b %h/%0d exp 1 %h/%0d",
                             k, instr_valid, instr, instr_pc, plan[k-1], k - 1);
                end
            end
            step();
        end
        run = 1'b0;
    endtask

    task automatic test_stall;
        do_reset();
        run = 1'b1;
        instr_ready = 1'b0;
        step();
        step();
        step();
        n_cmp++;
        if ({mem_addr, mem_noe, mem_cs, mem_read} !== {7'd2, 3'b100}) begin
            n_err++;
            $display("FAIL stall_hold got addr=%0d noe/cs/rd=%b%b%b exp 2 100",
                     mem_addr, mem_noe, mem_cs, mem_read);
        end
        n_cmp++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, 32'hB880_0000, 7'd0}) begin
            n_err++;
            $display("FAIL stall_head got v=%b %h/%0d exp 1 b8800000/0",
                     instr_valid, instr, instr_pc);
        end
        instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++;
            if ({instr_valid, instr, instr_pc} !== {1'b1, mem[k], 7'(k)}) begin
                n_err++;
                $display("FAIL stall_drain k=%0d got v=%b %h/%0d exp 1 %h/%0d",
                         k, instr_valid, instr, instr_pc, mem[k], k);
            end
            step();
        end
        run = 1'b0;
    endtask

    task automatic test_branch;
        do_reset();
        run = 1'b1;
        instr_ready = 1'b0;
        step();
        step();
        step();
        br_taken = 1'b1;
        br_target = 7'd9;
        #1;
        n_cmp++;
        if ({instr_valid, mem_noe} !== 2'b01) begin
            n_err++;
            $display("FAIL br_cycle got v=%b noe=%b exp v=0 noe=1", instr_valid, mem_noe);
        end
        step();
        br_taken = 1'b0;
        #1;
        n_cmp++;
        if ({mem_addr, mem_noe} !== {7'd9, 1'b0}) begin
            n_err++;
            $display("FAIL br_fetch got addr=%0d noe=%b exp 9 0", mem_addr, mem_noe);
        end
        step();
        n_cmp++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h1, 7'd9}) begin
            n_err++;
            $display("FAIL br_target got v=%b %h/%0d exp 1 00000001/9",
                     instr_valid, instr, instr_pc);
        end
        run = 1'b0;
    endtask

    task automatic test_end;
        do_reset();
        br_taken = 1'b1;
        br_target = 7'd126;
        step();
        br_taken = 1'b0;
        run = 1'b1;
        instr_ready = 1'b1;
        step();
        n_cmp++;
        if ({mem_addr, mem_noe} !== {7'd126, 1'b0}) begin
            n_err++;
            $display("FAIL end_126 got addr=%0d noe=%b exp 126 0", mem_addr, mem_noe);
        end
        step();
        n_cmp++;
        if ({mem_addr, mem_noe, instr_valid, instr_pc} !== {7'd127, 1'b0, 1'b1, 7'd126}) begin
            n_err++;
            $display("FAIL end_127 got addr=%0d noe=%b v=%b pc=%0d exp 127 0 1 126",
                     mem_addr, mem_noe, instr_valid, instr_pc);
        end
        step();
        if (WRAP) begin
            n_cmp++;
            if ({mem_addr, mem_noe} !== {7'd0, 1'b0}) begin
                n_err++;
                $display("FAIL end_wrap got addr=%0d noe=%b exp 0 0", mem_addr, mem_noe);
            end
        end else begin
            n_cmp++;
            if ({mem_noe, instr_valid, instr_pc} !== {1'b1, 1'b1, 7'd127}) begin
                n_err++;
                $display("FAIL end_stop got noe=%b v=%b pc=%0d exp 1 1 127",
                         mem_noe, instr_valid, instr_pc);
            end
            step();
            n_cmp++;
            if ({mem_noe, instr_valid} !== 2'b10) begin
                n_err++;
                $display("FAIL end_drain got noe=%b v=%b exp 1 0", mem_noe, instr_valid);
            end
            step();
            n_cmp++;
            if (mem_noe !== 1'b1) begin
                n_err++;
                $display("FAIL end_quiet got noe=%b exp 1", mem_noe);
            end
        end
        run = 1'b0;
    endtask

    task automatic test_reset_mid;
        do_reset();
        run = 1'b1;
        instr_ready = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({instr_valid, mem_noe, mem_addr, instr, instr_pc} !==
            {1'b0, 1'b1, 7'd0, 32'd0, 7'd0}) begin
            n_err++;
            $display("FAIL rst_mid got v=%b noe=%b addr=%0d instr=%h pc=%0d exp 0 1 0 0 0",
                     instr_valid, mem_noe, mem_addr, instr, instr_pc);
        end
        step();
        n_cmp++;
        if ({mem_addr, mem_noe} !== {7'd0, 1'b0}) begin
            n_err++;
            $display("FAIL rst_restart got addr=%0d noe=%b exp 0 0", mem_addr, mem_noe);
        end
        run = 1'b0;
    endtask

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] d;
    } ent_t;

    task automatic test_random;
        ent_t q[$];
        ent_t e;
        int   m_pc;
        int   m_mode;
        logic e_valid;
        logic e_fe;
        logic [DW-1:0] e_instr;
        logic [AW-1:0] e_ipc;
        for (int i = 0; i <= MAXA; i++) mem[i] = $urandom;
        do_reset();
        m_pc = 0;
        m_mode = 0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            run = ($urandom_range(0, 9) != 0);
            instr_ready = ($urandom_range(0, 2) != 0);
            br_taken = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) br_target = 7'(120 + $urandom_range(0, 7));
            else br_target = 7'($urandom);
            #1;
            e_valid = (q.size() != 0) && !br_taken;
            e_fe = (m_mode == 1) && !br_taken &&
                   ((q.size() < DEPTH) || (e_valid && instr_ready));
            e_instr = (q.size() != 0) ? q[0].d : '0;
            e_ipc = (q.size() != 0) ? q[0].pc : '0;
            n_cmp++;
            if ({mem_addr, mem_noe, mem_cs, mem_read, instr_valid, instr, instr_pc} !==
                {7'(m_pc), !e_fe, e_fe, e_fe, e_valid, e_instr, e_ipc}) begin
                n_err++;
                $display("FAIL rand c=%0d got a=%0d n/c/r=%b%b%b v=%b %h/%0d exp a=%0d fe=%b v=%b %h/%0d",
                         c, mem_addr, mem_noe, mem_cs, mem_read, instr_valid, instr,
                         instr_pc, m_pc, e_fe, e_valid, e_instr, e_ipc);
            end
            if (reset) begin
                q.delete();
                m_pc = 0;
                m_mode = 0;
            end else if (br_taken) begin
                q.delete();
                m_pc = int'(br_target);
                if (m_mode == 2) m_mode = 1;
                else if (m_mode == 1 && !run) m_mode = 0;
            end else begin
                if (e_valid && instr_ready) q.delete(0);
                if (e_fe) begin
                    e.pc = 7'(m_pc);
                    e.d = mem[m_pc];
                    q.push_back(e);
                end
                if (m_mode == 0 && run) m_mode = 1;
                else if (m_mode == 1) begin
                    if (e_fe && m_pc == MAXA && !WRAP) m_mode = 2;
                    else if (!run) m_mode = 0;
                end
                if (e_fe) m_pc = (m_pc + 1) % (MAXA + 1);
            end
            step();
        end
    endtask

    initial begin
        load_plan_mem();
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_end();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch initiator that drives the instruction memory's read port (address, active-low output enable, chip select, read strobe) and captures returned 32-bit words. Maintains the fetch PC, buffers fetched words in a small FIFO, and hands them to decode over a valid/ready handshake. Sits between the instruction memory and the decode stage. Supports branch redirect with flush.

## Interface
- ADDR_W, 7, instruction word address width (memory depth 2^ADDR_W)
- DATA_W, 32, instruction width
- BUF_DEPTH, 2, fetch buffer entries (power of two, ≥2)

- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- run  in  1  fetch enable from control
- mem_addr  out  ADDR_W  word address to instruction memory
- mem_read  out  1  read strobe, high on fetch cycles
- mem_noe  out  1  active-low output enable, low on fetch cycles
- mem_cs  out  1  chip select, high on fetch cycles
- mem_data  in  DATA_W  memory data; combinational from mem_addr when mem_noe=0, Z otherwise
- instr  out  DATA_W  FIFO head instruction, 0 when empty
- instr_pc  out  ADDR_W  address of FIFO head, 0 when empty
- instr_valid  out  1  head valid
- instr_ready  in  1  decode accepts head
- br_taken  in  1  redirect request
- br_target  in  ADDR_W  redirect address

## Operation
- States: IDLE, FETCH, END.
- IDLE: no fetch. run=1 → FETCH.
- FETCH: run=0 → IDLE (buffer and PC retained). Address 2^ADDR_W−1 fetched with wrap disabled → END.
- END: no fetch; buffer drains. br_taken → FETCH.
- pop = instr_valid & instr_ready.
- fetch_en = (state==FETCH) & !br_taken & (count<BUF_DEPTH | pop).
- fetch_en=1: mem_noe=0, mem_cs=1, mem_read=1, mem_addr=fetch_pc; at edge push {fetch_pc, mem_data}, fetch_pc+1.
- fetch_en=0: mem_noe=1, mem_cs=0, mem_read=0, mem_addr holds fetch_pc. mem_data is never sampled.
- instr_valid = (count!=0) & !br_taken.
- br_taken, any state except IDLE: at edge, buffer flushed (count=0), fetch_pc=br_target, no push or pop that cycle. In IDLE: fetch_pc=br_target, buffer flushed, state stays IDLE.
- Priority: reset > br_taken > push/pop. Simultaneous push and pop with full buffer is legal; count is unchanged.
- PC arithmetic is modulo 2^ADDR_W.

## Timing
- Reset values: fetch_pc=0, count=0, state=IDLE, mem_addr=0, mem_noe=1, mem_cs=0, mem_read=0, instr=0, instr_pc=0, instr_valid=0.
- Reset mid-operation discards buffered entries and returns to the reset values in the next cycle.
- Fetch-to-valid latency: 1 cycle. A word fetched in cycle N is instr_valid in cycle N+1.
- Sustained throughput: 1 instruction/cycle with instr_ready held high.
- Redirect: br_taken in cycle N; mem_addr=br_target with fetch in N+1; target instruction valid in N+2.
- run rising edge in cycle N: first fetch in N+1.
- Outputs mem_* and instr_valid are combinational from registered state plus br_taken/instr_ready. No other combinational input-to-output paths exist.

## Configuration
- IFETCH_WRAP_EN defined: fetch of address 2^ADDR_W−1 is followed by address 0; END is unreachable.
- IFETCH_WRAP_EN undefined: after fetching address 2^ADDR_W−1, the state moves to END; no further memory accesses occur until br_taken or reset.

## Test plan
- Memory model: mem[0]=0xB8800000, mem[1]=0xB8801001, mem[2]=0x00000008, mem[9]=0x00000001, remaining entries=0.
- Reset, then run=1 with instr_ready=1 -> mem_addr is 0,1,2 on consecutive cycles with mem_noe=0. One cycle later, instr/instr_pc are 0xB8800000/0, 0xB8801001/1, 0x00000008/2.
- run=1, instr_ready=0 -> two fetches (addr 0,1), then mem_noe=1, mem_cs=0, mem_addr=2 held, instr_valid=1 with instr=0xB8800000. Release instr_ready -> entries pc 0,1,2 delivered in order with no drop or duplicate.
- Buffer full, br_taken=1, br_target=9 -> instr_valid=0 that cycle. Next cycle mem_addr=9 with a fetch. Following cycle instr=0x00000001, instr_pc=9.
- fetch_pc=126, run=1 -> without IFETCH_WRAP_EN: fetches 126 and 127, then mem_noe stays 1 and instr_valid falls once the buffer drains. With IFETCH_WRAP_EN: the access after 127 is mem_addr=0.
- Buffer holding 2 entries, reset=1 for one cycle -> next cycle instr_valid=0, mem_noe=1, mem_addr=0, instr=0. After reset with run=1, fetching restarts at address 0.
